// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the iterative fixed-point divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_NEAREST = 1'b1;

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module fxp_div_step
  import fxp_div_pkg::*;
#(
  parameter int unsigned DEN_WIDTH = 9
) (
  input  logic [DEN_WIDTH-1:0] rem,
  input  logic                 in_bit,
  input  logic [DEN_WIDTH-1:0] divisor,
  output logic [DEN_WIDTH-1:0] rem_next_c,
  output logic                 q_bit_c
);

  logic [DEN_WIDTH:0]   shifted;
  logic [DEN_WIDTH-1:0] trial;

  assign shifted = {rem, in_bit};
  assign q_bit_c = (shifted >= {1'b0, divisor});
  // When the subtract succeeds the result is below the divisor, so DEN_WIDTH bits suffice.
  assign trial      = shifted[DEN_WIDTH-1:0] - divisor;
  assign rem_next_c = q_bit_c ? trial : shifted[DEN_WIDTH-1:0];

endmodule

// File: rtl/fxp_divider_iter.sv
// Iterative signed fixed-point divider: magnitude restoring division plus guard-bit rounding and saturation.
module fxp_divider_iter
  import fxp_div_pkg::*;
#(
  parameter int unsigned NUM_WIDTH = 17,
  parameter int unsigned DEN_WIDTH = 9,
  parameter int unsigned OUT_WIDTH = 17,
  parameter int unsigned DEN_FRAC  = 0,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [NUM_WIDTH-1:0] numerator,
  input  logic signed [DEN_WIDTH-1:0] denominator,
  input  logic                        round_mode,
  input  logic        [TAG_WIDTH-1:0] in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] quotient,
  output logic                        div_zero,
  output logic                        overflow,
  output logic        [TAG_WIDTH-1:0] out_tag
);

  localparam int unsigned ITER  = NUM_WIDTH + DEN_FRAC + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam int unsigned CW    = ((ITER > OUT_WIDTH) ? ITER : OUT_WIDTH) + 1;

  localparam logic [CW-1:0] LIM_NEG = CW'(1) << (OUT_WIDTH - 1);
  localparam logic [CW-1:0] LIM_POS = LIM_NEG - CW'(1);
  localparam logic signed [OUT_WIDTH-1:0] Q_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t state, state_next;
  logic   out_valid_d, in_ready_d;
  logic   accept;

  logic [ITER-1:0]      dq;
  logic [DEN_WIDTH-1:0] rem, den_mag, rem_next_c;
  logic                 q_bit_c;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q, num_neg_q, dz_q, round_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic [NUM_WIDTH-1:0]         num_mag_c;
  logic [DEN_WIDTH-1:0]         den_mag_c;
  logic [CW-1:0]                mag_c;
  logic signed [OUT_WIDTH-1:0]  q_fix_c;
  logic                         dz_fix_c, ov_fix_c;

  assign accept    = in_valid && in_ready;
  assign num_mag_c = numerator[NUM_WIDTH-1] ? NUM_WIDTH'(-numerator) : NUM_WIDTH'(numerator);
  assign den_mag_c = denominator[DEN_WIDTH-1] ? DEN_WIDTH'(-denominator) : DEN_WIDTH'(denominator);

  fxp_div_step #(
    .DEN_WIDTH (DEN_WIDTH)
  ) u_step (
    .rem        (rem),
    .in_bit     (dq[ITER-1]),
    .divisor    (den_mag),
    .rem_next_c (rem_next_c),
    .q_bit_c    (q_bit_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic; out_valid rises on the cycle after HOLD is entered
  always_comb begin
    state_next  = state;
    out_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (denominator == '0) ? FIX : DIV;
      end
      DIV: begin
        if (cnt == CNT_W'(ITER - 1)) state_next = FIX;
      end
      FIX: begin
        state_next = HOLD;
      end
      HOLD: begin
        out_valid_d = 1'b1;
        if (out_valid && out_ready) begin
          state_next  = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    in_ready_d = (state_next == IDLE);
  end

  // Quotient LSB is the guard (half) bit; rounding adds it back into the magnitude
  always_comb begin
    mag_c    = CW'(dq[ITER-1:1]) + CW'(round_q & dq[0]);
    q_fix_c  = '0;
    dz_fix_c = 1'b0;
    ov_fix_c = 1'b0;
    if (dz_q) begin
      q_fix_c  = num_neg_q ? Q_MIN : Q_MAX;
      dz_fix_c = 1'b1;
    end else if (neg_q) begin
      if (mag_c > LIM_NEG) begin
        q_fix_c  = Q_MIN;
        ov_fix_c = 1'b1;
      end else begin
        q_fix_c = $signed(OUT_WIDTH'(CW'(0) - mag_c));
      end
    end else if (mag_c > LIM_POS) begin
      q_fix_c  = Q_MAX;
      ov_fix_c = 1'b1;
    end else begin
      q_fix_c = $signed(OUT_WIDTH'(mag_c));
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq        <= '0;
      rem       <= '0;
      den_mag   <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      num_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      round_q   <= ROUND_TRUNC;
      tag_q     <= '0;
      quotient  <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (accept) begin
        dq        <= {num_mag_c, {(DEN_FRAC+1){1'b0}}};
        rem       <= '0;
        den_mag   <= den_mag_c;
        cnt       <= '0;
        neg_q     <= numerator[NUM_WIDTH-1] ^ denominator[DEN_WIDTH-1];
        num_neg_q <= numerator[NUM_WIDTH-1];
        dz_q      <= (denominator == '0);
        round_q   <= round_mode;
        tag_q     <= in_tag;
      end
      if (state == DIV) begin
        dq  <= {dq[ITER-2:0], q_bit_c};
        rem <= rem_next_c;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FIX) begin
        quotient <= q_fix_c;
        div_zero <= dz_fix_c;
        overflow <= ov_fix_c;
        out_tag  <= tag_q;
      end
      if (state == HOLD && out_valid && out_ready) begin
        div_zero <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fxp_divider_iter.md
FXP_DIVIDER_ITER -- requirements
Module: fxp_divider_iter

Interface
REQ-001 SHALL have parameters: NUM_WIDTH, default 17, signed numerator width; DEN_WIDTH, default 9, signed denominator width; OUT_WIDTH, default 17, signed quotient width; DEN_FRAC, default 0, denominator fractional bits; TAG_WIDTH, default 4, pass-through tag width.
REQ-002 SHALL use one clock with an asynchronous, active-high reset; ports: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-003 Inputs: in_valid 1 (request); numerator NUM_WIDTH (signed); denominator DEN_WIDTH (signed); round_mode 1 (0 = truncate toward zero, 1 = round half away from zero); in_tag TAG_WIDTH.
REQ-004 Outputs: in_ready 1; out_valid 1; quotient OUT_WIDTH (signed, same scaling as numerator); div_zero 1; overflow 1; out_tag TAG_WIDTH; out_ready 1 (input, downstream accept).

Function
REQ-005 SHALL compute q = (numerator * 2^DEN_FRAC) / denominator, signed, result scaled like numerator.
REQ-006 SHALL accept a request when in_valid && in_ready on a rising clk edge; all operands, round_mode and in_tag SHALL be registered at accept.
REQ-007 SHALL implement FSM states IDLE, DIV, FIX, HOLD; in_ready = 1 only in IDLE.
REQ-008 IDLE -> DIV on accept with nonzero denominator; IDLE -> FIX on accept with zero denominator.
REQ-009 DIV SHALL perform unsigned restoring division on magnitudes, one quotient bit per cycle, for ITER = NUM_WIDTH + DEN_FRAC + 1 cycles (last bit = guard bit), then -> FIX.
REQ-010 FIX (one cycle) SHALL drop the guard bit (truncate), or add the guard bit to the magnitude (round), apply sign = sign(num) XOR sign(den), saturate, then -> HOLD.
REQ-011 HOLD SHALL assert out_valid with quotient, flags and out_tag stable until out_ready; on out_valid && out_ready -> IDLE.
REQ-012 Latency accept-to-out_valid SHALL be ITER + 2 cycles (20 at defaults); zero denominator SHALL give 2 cycles.
REQ-013 Zero denominator: quotient = 2^(OUT_WIDTH-1)-1 if numerator >= 0, else -2^(OUT_WIDTH-1); div_zero = 1; overflow = 0.
REQ-014 Result outside OUT_WIDTH signed range SHALL saturate to the nearest bound with overflow = 1 (covers most-negative / -1).
REQ-015 div_zero and overflow SHALL be 0 for in-range results and valid only with out_valid.
REQ-016 in_valid while busy SHALL be ignored (no accept); out_ready outside HOLD SHALL be ignored.

Reset
REQ-017 reset SHALL asynchronously force state IDLE, in_ready 1 once released, out_valid 0, quotient 0, div_zero 0, overflow 0, out_tag 0.
REQ-018 Reset mid-DIV/FIX/HOLD SHALL abort the operation; no out_valid SHALL appear for it.

Structure
REQ-019 Package fxp_div_pkg SHALL hold the state enum and ROUND_TRUNC/ROUND_NEAREST constants.
REQ-020 One sub-module fxp_div_step (combinational restoring step: trial subtract, next remainder, quotient bit) SHALL be instantiated once inside the iterative datapath.

Verification (defaults, Q9.8 numerator)
REQ-021 num 65280, den 7, truncate -> quotient 9325 (0x246D), flags 0, out_valid 20 cycles after accept; round -> 9326.
REQ-022 num -38400, den 7 -> truncate -5485, round -5486; num 25600, den 3 -> 8533 in both modes; num 1280, den 2 -> 640.
REQ-023 num 2048, den 0 -> quotient 65535, div_zero 1, out_valid 2 cycles after accept; num -2048, den 0 -> -65536.
REQ-024 num -65536, den -1 -> quotient 65535, overflow 1; num 65280, den -1 -> -65280, overflow 0.
REQ-025 out_ready held low 5 cycles in HOLD -> outputs stable, in_ready 0, second in_valid not accepted; tag returned unchanged.
REQ-026 reset asserted at DIV cycle 8 -> out_valid never asserts for that op; next request completes correctly.
